// File: rtl/sysarr_input_loader.sv
// sysarr_input_loader
// Accepts one N x N operand matrix as N row beats, parallel-loads each row
// into its per-row FIFO, then drives the FIFO shift strobes with a diagonal
// skew so FIFO i starts shifting i cycles after FIFO 0.
module sysarr_input_loader #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*N-1:0]     in_row,
  input  logic                arr_ready,
  input  logic                flush,
  output logic [N-1:0]        fifo_load,
  output logic [N-1:0]        fifo_shift,
  output logic [N*DW*N-1:0]   fifo_load_values,
  output logic                busy,
  output logic                pass_done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (N > 1) ? $clog2(2*N-1) : 1;
  localparam logic [RW-1:0] RC_LAST = RW'(N-1);
  localparam logic [TW-1:0] T_LAST  = TW'(2*N-2);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [TW-1:0] t_q, t_d;
  logic          hs;

  logic [N-1:0]  load_d;
  logic [N-1:0]  shift_d;
  logic          busy_d;
  logic          done_d;

  // Rows are only accepted while filling and never on a flush cycle.
  assign in_ready = (state_q == S_FILL) & ~flush;
  assign hs       = in_valid & in_ready;

  // State and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_FILL;
      rc_q    <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      t_q     <= t_d;
    end
  end

  // Next-state and counter update; flush overrides everything.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    t_d     = t_q;
    if (flush) begin
      state_d = S_FILL;
      rc_d    = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (hs) begin
            if (rc_q == RC_LAST) begin
              state_d = S_WAIT;
              rc_d    = '0;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (arr_ready) begin
            state_d = S_STREAM;
            t_d     = '0;
          end
        end
        S_STREAM: begin
          if (t_q == T_LAST) begin
            state_d = S_FILL;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
        default: begin
          state_d = S_FILL;
          rc_d    = '0;
          t_d     = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs, derived from the next state so
  // the first shift strobe appears in the first STREAM cycle.
  always_comb begin
    load_d  = '0;
    shift_d = '0;
    for (int r = 0; r < N; r++) begin
      if (hs && (rc_q == RW'(r))) load_d[r] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      shift_d[i] = (state_d == S_STREAM) &&
                   (t_d >= TW'(i)) && (t_d <= TW'(i + N - 1));
    end
    busy_d = (state_d != S_FILL);
    done_d = (state_q == S_STREAM) && (t_q == T_LAST) && !flush;
  end

  // Registered strobes and status.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fifo_load  <= '0;
      fifo_shift <= '0;
      busy       <= 1'b0;
      pass_done  <= 1'b0;
    end else begin
      fifo_load  <= load_d;
      fifo_shift <= shift_d;
      busy       <= busy_d;
      pass_done  <= done_d;
    end
  end

  // Capture each handshaked row into its FIFO's load slice; other slices hold.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fifo_load_values <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (load_d[r]) fifo_load_values[DW*N*r +: DW*N] <= in_row;
      end
    end
  end

endmodule

// File: tb/tb_sysarr_input_loader.sv
// Self-checking bench for sysarr_input_loader: a behavioural model tracks
// rows accepted and stream cycle index, and one process compares every cycle.
module tb_sysarr_input_loader;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int RB = DW*N;
  localparam int VW = N*DW*N;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_valid = 1'b0;
  logic          arr_ready = 1'b0;
  logic          flush = 1'b0;
  logic [RB-1:0] in_row = '0;
  logic          in_ready;
  logic [N-1:0]  fifo_load;
  logic [N-1:0]  fifo_shift;
  logic [VW-1:0] fifo_load_values;
  logic          busy;
  logic          pass_done;

  sysarr_input_loader #(.DW(DW), .N(N)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_row           (in_row),
    .arr_ready        (arr_ready),
    .flush            (flush),
    .fifo_load        (fifo_load),
    .fifo_shift       (fifo_shift),
    .fifo_load_values (fifo_load_values),
    .busy             (busy),
    .pass_done        (pass_done)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: m_rows = rows accepted in this pass (N means fill complete),
  // m_sc = stream cycle index, -1 when not streaming.
  int            m_rows = 0;
  int            m_sc = -1;
  logic [VW-1:0] m_vals = '0;
  logic [N-1:0]  e_load = '0;
  logic [N-1:0]  e_shift = '0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;

  logic [3:0] lseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] sseq [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000};

  task automatic chk(input string name, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] row_lit(input int r);
    logic [63:0] base;
    logic [63:0] step;
    base = 64'h0001_0002_0003_0004;
    step = 64'h0010_0010_0010_0010;
    return base + 64'(r) * step;
  endfunction

  // Model update on every rising edge followed by the per-cycle comparison.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (!nRST) begin
        m_rows  = 0;
        m_sc    = -1;
        m_vals  = '0;
        e_load  = '0;
        e_shift = '0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
      end else begin
        e_load = '0;
        e_done = 1'b0;
        if (flush) begin
          m_rows = 0;
          m_sc   = -1;
        end else if (m_rows < N) begin
          if (in_valid) begin
            m_vals[RB*m_rows +: RB] = in_row;
            e_load[m_rows] = 1'b1;
            m_rows++;
          end
        end else if (m_sc < 0) begin
          if (arr_ready) m_sc = 0;
        end else if (m_sc == 2*N-2) begin
          m_sc   = -1;
          m_rows = 0;
          e_done = 1'b1;
        end else begin
          m_sc++;
        end
        e_busy = (m_rows == N);
        for (int i = 0; i < N; i++)
          e_shift[i] = (m_sc >= 0) && (i <= m_sc) && (m_sc < i + N);
      end
      chk("fifo_load", fifo_load, e_load);
      chk("fifo_shift", fifo_shift, e_shift);
      chk("fifo_load_values", fifo_load_values, m_vals);
      chk("busy", busy, e_busy);
      chk("pass_done", pass_done, e_done);
      @(negedge CLK); #1;
      chk("in_ready", in_ready, (m_rows < N) && !flush);
    end
  end

  task automatic fill_rows(input int n, input bit gaps);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 200) begin
      @(negedge CLK);
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_row   = {$urandom, $urandom};
      #1;
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    if (acc < n) begin
      tests++;
      fails++;
      $display("FAIL fill_timeout: accepted %0d rows, required %0d", acc, n);
    end
  endtask

  task automatic wait_sc(input int v);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge CLK);
      if (m_sc == v) hit = 1'b1;
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout: stream index %0d, required %0d", m_sc, v);
    end
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    logic [RB-1:0] r0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_values", fifo_load_values, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;

    // Single pass with in_valid and arr_ready held high.
    for (int r = 0; r < N; r++) begin
      @(negedge CLK);
      in_valid  = 1'b1;
      arr_ready = 1'b1;
      in_row    = row_lit(r);
      @(posedge CLK); #1;
      chk("sp_load", fifo_load, lseq[r]);
      chk("sp_slice", fifo_load_values[RB*r +: RB], row_lit(r));
    end
    chk("sp_wait_busy", busy, 1'b1);
    chk("sp_wait_shift", fifo_shift, 4'b0000);
    @(negedge CLK);
    in_valid = 1'b0;
    for (int s = 0; s < 2*N-1; s++) begin
      @(posedge CLK); #1;
      chk("sp_shift", fifo_shift, sseq[s]);
    end
    @(posedge CLK); #1;
    chk("sp_done", pass_done, 1'b1);
    chk("sp_done_ready", in_ready, 1'b1);
    @(negedge CLK);
    arr_ready = 1'b0;
    @(posedge CLK); #1;
    chk("sp_done_pulse", pass_done, 1'b0);

    // WAIT hold with a gappy fill.
    fill_rows(N, 1'b1);
    @(negedge CLK);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      chk("wait_busy", busy, 1'b1);
      chk("wait_ready", in_ready, 1'b0);
      chk("wait_shift", fifo_shift, 4'b0000);
    end
    @(negedge CLK);
    arr_ready = 1'b1;
    @(posedge CLK); #1;
    chk("wait_release", fifo_shift, 4'b0001);
    @(negedge CLK);
    arr_ready = 1'b0;
    repeat (8) @(negedge CLK);

    // Flush mid-fill, then a refill that restarts at FIFO 0.
    fill_rows(2, 1'b0);
    @(negedge CLK);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_row   = {$urandom, $urandom};
    @(posedge CLK); #1;
    chk("mf_no_load", fifo_load, 4'b0000);
    @(negedge CLK);
    flush    = 1'b0;
    in_valid = 1'b1;
    r0       = {$urandom, $urandom};
    in_row   = r0;
    @(posedge CLK); #1;
    chk("mf_restart", fifo_load, 4'b0001);
    chk("mf_slice0", fifo_load_values[RB-1:0], r0);
    fill_rows(N-1, 1'b1);
    @(negedge CLK);
    in_valid  = 1'b0;
    arr_ready = 1'b1;

    // Flush mid-stream at t=3.
    wait_sc(3);
    flush = 1'b1;
    @(posedge CLK); #1;
    chk("ms_shift", fifo_shift, 4'b0000);
    chk("ms_done", pass_done, 1'b0);
    @(negedge CLK);
    flush     = 1'b0;
    arr_ready = 1'b0;
    #1;
    chk("ms_ready", in_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      chk("ms_no_done", pass_done, 1'b0);
    end

    // Asynchronous reset in the middle of a stream at t=2.
    fill_rows(N, 1'b1);
    @(negedge CLK);
    in_valid  = 1'b0;
    arr_ready = 1'b1;
    wait_sc(2);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_shift", fifo_shift, 4'b0000);
    chk("ar_busy", busy, 1'b0);
    chk("ar_values", fifo_load_values, '0);
    @(negedge CLK);
    nRST      = 1'b1;
    arr_ready = 1'b0;
    #1;
    chk("ar_ready", in_ready, 1'b1);
    chk("ar_idle", busy, 1'b0);

    // Randomized soak: handshakes, array readiness and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_row    = {$urandom, $urandom};
      arr_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    arr_ready = 1'b0;
    flush     = 1'b0;
    repeat (20) @(negedge CLK);
    @(posedge CLK); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1, "watchdog");
  end

endmodule
